// File: rtl/lzw_reverse_deframer_if.sv
// Bundle of the GMII receive inputs and the downstream FIFO / dictionary ports of the
// LZW reverse deframer. The slave side is the deframer; the master side is its environment.
interface lzw_reverse_deframer_if;
  logic [7:0]  I_gmii_rxd;
  logic        I_gmii_rxdv;
  logic        I_gmii_rxerr;
  logic        O_fifo_head_wr;
  logic [8:0]  O_fifo_head_wdata;
  logic        I_fifo_head_full;
  logic        O_fifo_pload_wr;
  logic [8:0]  O_fifo_pload_wdata;
  logic        I_fifo_pload_full;
  logic        O_fifo_cmprs_wr;
  logic [15:0] O_fifo_cmprs_wdata;
  logic        I_fifo_cmprs_full;
  logic        O_dict_rxen;
  logic [7:0]  O_dict_rxd;

  modport master (
    output I_gmii_rxd, I_gmii_rxdv, I_gmii_rxerr,
    output I_fifo_head_full, I_fifo_pload_full, I_fifo_cmprs_full,
    input  O_fifo_head_wr, O_fifo_head_wdata,
    input  O_fifo_pload_wr, O_fifo_pload_wdata,
    input  O_fifo_cmprs_wr, O_fifo_cmprs_wdata,
    input  O_dict_rxen, O_dict_rxd
  );

  modport slave (
    input  I_gmii_rxd, I_gmii_rxdv, I_gmii_rxerr,
    input  I_fifo_head_full, I_fifo_pload_full, I_fifo_cmprs_full,
    output O_fifo_head_wr, O_fifo_head_wdata,
    output O_fifo_pload_wr, O_fifo_pload_wdata,
    output O_fifo_cmprs_wr, O_fifo_cmprs_wdata,
    output O_dict_rxen, O_dict_rxd
  );
endinterface

// File: rtl/lzw_reverse_deframer.sv
// Parses GMII receive bytes into header, payload, compressed-code and dictionary streams.
// Malformed frames are dropped, flagged with a one-cycle pulse and counted.
//
// state  | meaning
// IDLE   | waiting for a 0x55 preamble byte with rxdv high
// PRE    | inside preamble, waiting for SFD 0xD5
// HEAD   | forwarding HEAD_LEN header bytes to the header FIFO
// TYPE   | capturing the frame type byte
// LEN_H  | capturing the high length byte
// LEN_L  | capturing the low length byte and validating type/length
// BODY   | routing LEN body bytes to the selected destination
// TAIL   | ignoring trailing bytes until rxdv falls, then frame done
// DROP   | discarding the rest of a bad frame until rxdv falls
module lzw_reverse_deframer #(
  parameter int unsigned HEAD_LEN = 14,
  parameter int unsigned MAX_LEN  = 1500
) (
  input  logic                   I_sys_clk,
  input  logic                   I_sys_rst,
  lzw_reverse_deframer_if.slave  bus,
  output logic                   O_frame_done,
  output logic                   O_frame_err,
  output logic [15:0]            O_err_cnt
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE,
    S_HEAD,
    S_TYPE,
    S_LEN_H,
    S_LEN_L,
    S_BODY,
    S_TAIL,
    S_DROP
  } state_t;

  localparam logic [1:0] T_PLOAD = 2'd0;
  localparam logic [1:0] T_CMPRS = 2'd1;
  localparam logic [1:0] T_HEAD  = 2'd3;

  state_t      state_q, state_d;
  logic [7:0]  head_cnt_q, head_cnt_d;
  logic [15:0] body_cnt_q, body_cnt_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  len_h_q, len_h_d;
  logic [1:0]  type_q, type_d;
  logic [7:0]  code_hi_q, code_hi_d;
  logic        hold_q, hold_d;

  logic        head_wr_q, head_wr_d;
  logic [8:0]  head_wdata_q, head_wdata_d;
  logic        pload_wr_q, pload_wr_d;
  logic [8:0]  pload_wdata_q, pload_wdata_d;
  logic        cmprs_wr_q, cmprs_wr_d;
  logic [15:0] cmprs_wdata_q, cmprs_wdata_d;
  logic        dict_en_q, dict_en_d;
  logic [7:0]  dict_byte_q, dict_byte_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic        fail;
  logic        rx_bad;
  logic        head_last;
  logic        body_last;
  logic [15:0] len_v;
  logic [7:0]  rxd;
  logic        rxdv;
  logic        rxerr;

  assign rxd   = bus.I_gmii_rxd;
  assign rxdv  = bus.I_gmii_rxdv;
  assign rxerr = bus.I_gmii_rxerr;

  always_comb begin
    state_d       = state_q;
    head_cnt_d    = head_cnt_q;
    body_cnt_d    = body_cnt_q;
    len_d         = len_q;
    len_h_d       = len_h_q;
    type_d        = type_q;
    code_hi_d     = code_hi_q;
    // after reset, stay deaf until the frame in flight ends
    hold_d        = hold_q & rxdv;
    head_wr_d     = 1'b0;
    head_wdata_d  = head_wdata_q;
    pload_wr_d    = 1'b0;
    pload_wdata_d = pload_wdata_q;
    cmprs_wr_d    = 1'b0;
    cmprs_wdata_d = cmprs_wdata_q;
    dict_en_d     = 1'b0;
    dict_byte_d   = dict_byte_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    err_cnt_d     = err_cnt_q;
    fail          = 1'b0;
    rx_bad        = !rxdv || rxerr;
    len_v         = {len_h_q, rxd};
    head_last     = (head_cnt_q == 8'(HEAD_LEN - 1));
    body_last     = (body_cnt_q == len_q - 16'd1);

    case (state_q)
      S_IDLE: begin
        if (!hold_q && rxdv && rxd == 8'h55) state_d = S_PRE;
      end
      S_PRE: begin
        if (!rxdv) begin
          state_d = S_IDLE;
        end else if (rxerr) begin
          fail = 1'b1;
        end else if (rxd == 8'hD5) begin
          state_d    = S_HEAD;
          head_cnt_d = 8'd0;
        end else if (rxd != 8'h55) begin
          fail = 1'b1;
        end
      end
      S_HEAD: begin
        if (rx_bad || bus.I_fifo_head_full) begin
          fail = 1'b1;
        end else begin
          head_wr_d    = 1'b1;
          head_wdata_d = {head_last, rxd};
          if (head_last) state_d = S_TYPE;
          else           head_cnt_d = head_cnt_q + 8'd1;
        end
      end
      S_TYPE: begin
        if (rx_bad || rxd > 8'h03) begin
          fail = 1'b1;
        end else begin
          type_d  = rxd[1:0];
          state_d = S_LEN_H;
        end
      end
      S_LEN_H: begin
        if (rx_bad) begin
          fail = 1'b1;
        end else begin
          len_h_d = rxd;
          state_d = S_LEN_L;
        end
      end
      S_LEN_L: begin
        if (rx_bad || len_v > 16'(MAX_LEN) ||
            (type_q == T_CMPRS && len_v[0]) ||
            (type_q == T_HEAD && len_v != 16'd0)) begin
          fail = 1'b1;
        end else begin
          len_d      = len_v;
          body_cnt_d = 16'd0;
          state_d    = (len_v == 16'd0) ? S_TAIL : S_BODY;
        end
      end
      S_BODY: begin
        if (rx_bad) begin
          fail = 1'b1;
        end else begin
          case (type_q)
            T_PLOAD: begin
              if (bus.I_fifo_pload_full) begin
                fail = 1'b1;
              end else begin
                pload_wr_d    = 1'b1;
                pload_wdata_d = {body_last, rxd};
              end
            end
            T_CMPRS: begin
              // even body index carries the high byte of a code, odd index completes it
              if (!body_cnt_q[0]) begin
                code_hi_d = rxd;
              end else if (bus.I_fifo_cmprs_full) begin
                fail = 1'b1;
              end else begin
                cmprs_wr_d    = 1'b1;
                cmprs_wdata_d = {code_hi_q, rxd};
              end
            end
            default: begin
              dict_en_d   = 1'b1;
              dict_byte_d = rxd;
            end
          endcase
          if (!fail) begin
            body_cnt_d = body_cnt_q + 16'd1;
            if (body_last) state_d = S_TAIL;
          end
        end
      end
      S_TAIL: begin
        if (!rxdv) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (rxerr) begin
          fail = 1'b1;
        end
      end
      S_DROP: begin
        if (!rxdv) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (fail) begin
      state_d = S_DROP;
      err_d   = 1'b1;
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_sys_rst) begin
      state_q       <= S_IDLE;
      head_cnt_q    <= 8'd0;
      body_cnt_q    <= 16'd0;
      len_q         <= 16'd0;
      len_h_q       <= 8'd0;
      type_q        <= 2'd0;
      code_hi_q     <= 8'd0;
      hold_q        <= 1'b1;
      head_wr_q     <= 1'b0;
      head_wdata_q  <= 9'd0;
      pload_wr_q    <= 1'b0;
      pload_wdata_q <= 9'd0;
      cmprs_wr_q    <= 1'b0;
      cmprs_wdata_q <= 16'd0;
      dict_en_q     <= 1'b0;
      dict_byte_q   <= 8'd0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      err_cnt_q     <= 16'd0;
    end else begin
      state_q       <= state_d;
      head_cnt_q    <= head_cnt_d;
      body_cnt_q    <= body_cnt_d;
      len_q         <= len_d;
      len_h_q       <= len_h_d;
      type_q        <= type_d;
      code_hi_q     <= code_hi_d;
      hold_q        <= hold_d;
      head_wr_q     <= head_wr_d;
      head_wdata_q  <= head_wdata_d;
      pload_wr_q    <= pload_wr_d;
      pload_wdata_q <= pload_wdata_d;
      cmprs_wr_q    <= cmprs_wr_d;
      cmprs_wdata_q <= cmprs_wdata_d;
      dict_en_q     <= dict_en_d;
      dict_byte_q   <= dict_byte_d;
      done_q        <= done_d;
      err_q         <= err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign bus.O_fifo_head_wr     = head_wr_q;
  assign bus.O_fifo_head_wdata  = head_wdata_q;
  assign bus.O_fifo_pload_wr    = pload_wr_q;
  assign bus.O_fifo_pload_wdata = pload_wdata_q;
  assign bus.O_fifo_cmprs_wr    = cmprs_wr_q;
  assign bus.O_fifo_cmprs_wdata = cmprs_wdata_q;
  assign bus.O_dict_rxen        = dict_en_q;
  assign bus.O_dict_rxd         = dict_byte_q;
  assign O_frame_done           = done_q;
  assign O_frame_err            = err_q;
  assign O_err_cnt              = err_cnt_q;

endmodule

// File: tb/tb_lzw_reverse_deframer.sv
// Bench for lzw_reverse_deframer: directed vector table, hand-built corner frames and
// random frames checked against a frame-level reference model.
module tb_lzw_reverse_deframer;
  localparam int HL = 14;
  localparam int ML = 1500;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #2 clk = ~clk;

  lzw_reverse_deframer_if bus();
  logic        done;
  logic        ferr;
  logic [15:0] ecnt;

  lzw_reverse_deframer #(.HEAD_LEN(HL), .MAX_LEN(ML)) dut (
    .I_sys_clk    (clk),
    .I_sys_rst    (rst),
    .bus          (bus),
    .O_frame_done (done),
    .O_frame_err  (ferr),
    .O_err_cnt    (ecnt)
  );

  typedef struct {
    logic [7:0] d;
    logic       er;
    logic       hf;
    logic       pf;
    logic       cf;
    logic       rs;
  } beat_t;

  typedef struct {
    logic [7:0]  ft;
    int          len;
    int          nsend;
    int          errpos;
    logic [63:0] body;
    bit          e_done;
    bit          e_err;
    int          e_nout;
    logic [15:0] e_last;
  } vec_t;

  int total = 0;
  int bad = 0;
  int exp_ecnt = 0;

  beat_t       fq[$];
  int          body_start;
  logic [7:0]  bodyarr [0:2047];
  logic [15:0] qh[$], qp[$], qc[$], qd[$];
  logic [15:0] eh[$], ep[$], ec[$], ed[$];
  int          ndone, nerr, nboth;
  bit          e_done, e_err;

  always @(negedge clk) begin
    if (bus.O_fifo_head_wr)  qh.push_back({7'd0, bus.O_fifo_head_wdata});
    if (bus.O_fifo_pload_wr) qp.push_back({7'd0, bus.O_fifo_pload_wdata});
    if (bus.O_fifo_cmprs_wr) qc.push_back(bus.O_fifo_cmprs_wdata);
    if (bus.O_dict_rxen)     qd.push_back({8'd0, bus.O_dict_rxd});
    if (done) ndone++;
    if (ferr) nerr++;
    if (done && ferr) nboth++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int mism(input logic [15:0] a[$], input logic [15:0] e[$]);
    int n;
    int m;
    n = (a.size() > e.size()) ? a.size() - e.size() : e.size() - a.size();
    m = (a.size() < e.size()) ? a.size() : e.size();
    for (int i = 0; i < m; i++) if (a[i] !== e[i]) n++;
    return n;
  endfunction

  task automatic idle(input int n);
    bus.I_gmii_rxdv = 1'b0;
    bus.I_gmii_rxd = 8'd0;
    bus.I_gmii_rxerr = 1'b0;
    bus.I_fifo_head_full = 1'b0;
    bus.I_fifo_pload_full = 1'b0;
    bus.I_fifo_cmprs_full = 1'b0;
    rst = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic build(input logic [7:0] ft, input int len, input int nsend, input int npre,
                       input int ntail, input logic [7:0] hbase);
    beat_t b;
    b = '{default: '0};
    fq.delete();
    b.d = 8'h55;
    for (int i = 0; i < npre; i++) fq.push_back(b);
    b.d = 8'hD5; fq.push_back(b);
    for (int i = 0; i < HL; i++) begin b.d = hbase + 8'(i); fq.push_back(b); end
    b.d = ft;          fq.push_back(b);
    b.d = 8'(len >> 8); fq.push_back(b);
    b.d = 8'(len);      fq.push_back(b);
    body_start = fq.size();
    for (int i = 0; i < nsend; i++) begin b.d = bodyarr[i]; fq.push_back(b); end
    for (int i = 0; i < ntail; i++) begin b.d = 8'($urandom); fq.push_back(b); end
  endtask

  task automatic run_frame();
    qh.delete(); qp.delete(); qc.delete(); qd.delete();
    ndone = 0; nerr = 0; nboth = 0;
    foreach (fq[i]) begin
      bus.I_gmii_rxdv = 1'b1;
      bus.I_gmii_rxd = fq[i].d;
      bus.I_gmii_rxerr = fq[i].er;
      bus.I_fifo_head_full = fq[i].hf;
      bus.I_fifo_pload_full = fq[i].pf;
      bus.I_fifo_cmprs_full = fq[i].cf;
      rst = fq[i].rs;
      @(posedge clk);
      #1;
    end
    idle(3);
  endtask

  // frame-level expectation: which body bytes are accepted, and where they go
  task automatic model(input logic [7:0] ft, input int len, input int nsend, input int errpos,
                       input logic [7:0] hbase);
    int stop;
    bit er;
    eh.delete(); ep.delete(); ec.delete(); ed.delete();
    for (int i = 0; i < HL; i++) eh.push_back({7'd0, (i == HL - 1), 8'(hbase + 8'(i))});
    er = 0;
    stop = 0;
    if (ft > 8'd3) er = 1;
    else if (len > ML || (ft == 8'd1 && len % 2 == 1) || (ft == 8'd3 && len != 0)) er = 1;
    else begin
      stop = len;
      if (nsend < len) begin stop = nsend; er = 1; end
      if (errpos >= 0) begin er = 1; if (errpos < stop) stop = errpos; end
      for (int i = 0; i < stop; i++) begin
        if (ft == 8'd0) ep.push_back({7'd0, (i == len - 1), bodyarr[i]});
        else if (ft == 8'd2) ed.push_back({8'd0, bodyarr[i]});
        else if (ft == 8'd1 && i % 2 == 1) ec.push_back({bodyarr[i-1], bodyarr[i]});
      end
    end
    e_done = !er;
    e_err = er;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_head"}, mism(qh, eh), 0);
    chk({tag, "_pload"}, mism(qp, ep), 0);
    chk({tag, "_cmprs"}, mism(qc, ec), 0);
    chk({tag, "_dict"}, mism(qd, ed), 0);
    chk({tag, "_done"}, ndone, {31'd0, e_done});
    chk({tag, "_err"}, nerr, {31'd0, e_err});
    chk({tag, "_both"}, nboth, 0);
    chk({tag, "_errcnt"}, {16'd0, ecnt}, exp_ecnt);
  endtask

  vec_t tbl[14];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] bb;
    int ntail;
    int act_n;
    logic [15:0] act_last;
    logic [7:0] ft;
    int len, nsend, errpos, npre, r;
    logic [7:0] hb;

    tbl[0]  = '{8'h00, 4,    4,    -1, 64'hA1A2A3A4_00000000, 1, 0, 4,    16'h01A4};
    tbl[1]  = '{8'h01, 4,    4,    -1, 64'h0102FF10_00000000, 1, 0, 2,    16'hFF10};
    tbl[2]  = '{8'h02, 3,    3,    -1, 64'h112233_0000000000, 1, 0, 3,    16'h0033};
    tbl[3]  = '{8'h00, 8,    8,    1,  64'h0102030405060708,  0, 1, 1,    16'h0001};
    tbl[4]  = '{8'h01, 3,    3,    -1, 64'h0102030000000000,  0, 1, 0,    16'h0000};
    tbl[5]  = '{8'h03, 0,    0,    -1, 64'h0,                 1, 0, 0,    16'h0000};
    tbl[6]  = '{8'h03, 2,    2,    -1, 64'h0102000000000000,  0, 1, 0,    16'h0000};
    tbl[7]  = '{8'h07, 2,    2,    -1, 64'h0102000000000000,  0, 1, 0,    16'h0000};
    tbl[8]  = '{8'h00, 1501, 3,    -1, 64'h0102030000000000,  0, 1, 0,    16'h0000};
    tbl[9]  = '{8'h00, 1500, 1500, -1, 64'hA1A2A3A4A5A6A7A8,  1, 0, 1500, 16'h01DB};
    tbl[10] = '{8'h00, 4,    2,    -1, 64'hA1A2A3A4_00000000, 0, 1, 2,    16'h00A2};
    tbl[11] = '{8'h00, 1,    1,    -1, 64'h5A00000000000000,  1, 0, 1,    16'h015A};
    tbl[12] = '{8'h02, 2,    2,    3,  64'h1122000000000000,  0, 1, 2,    16'h0022};
    tbl[13] = '{8'h01, 0,    0,    -1, 64'h0,                 1, 0, 0,    16'h0000};

    rst = 1'b1;
    idle(0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_head_wr", {31'd0, bus.O_fifo_head_wr}, 0);
    chk("rst_pload_wr", {31'd0, bus.O_fifo_pload_wr}, 0);
    chk("rst_cmprs_wr", {31'd0, bus.O_fifo_cmprs_wr}, 0);
    chk("rst_dict_en", {31'd0, bus.O_dict_rxen}, 0);
    chk("rst_done_err", {30'd0, done, ferr}, 0);
    chk("rst_errcnt", {16'd0, ecnt}, 0);
    rst = 1'b0;
    idle(2);

    for (int k = 0; k < 14; k++) begin
      bb = tbl[k].body;
      for (int i = 0; i < 2048; i++) bodyarr[i] = (i < 8) ? bb[63 - 8*i -: 8] : 8'(i);
      ntail = (tbl[k].nsend < tbl[k].len) ? 0 : 2;
      build(tbl[k].ft, tbl[k].len, tbl[k].nsend, 2, ntail, 8'h30);
      if (tbl[k].errpos >= 0) fq[body_start + tbl[k].errpos].er = 1'b1;
      run_frame();
      act_n = qp.size() + qc.size() + qd.size();
      act_last = 16'd0;
      if (tbl[k].ft == 8'h00 && qp.size() > 0) act_last = qp[$];
      if (tbl[k].ft == 8'h01 && qc.size() > 0) act_last = qc[$];
      if (tbl[k].ft == 8'h02 && qd.size() > 0) act_last = qd[$];
      exp_ecnt += int'(tbl[k].e_err);
      chk($sformatf("vec%0d_nhead", k), qh.size(), HL);
      chk($sformatf("vec%0d_headlast", k), (qh.size() > 0) ? {16'd0, qh[$]} : 32'd0, 32'h13D);
      chk($sformatf("vec%0d_nout", k), act_n, tbl[k].e_nout);
      chk($sformatf("vec%0d_last", k), {16'd0, act_last}, {16'd0, tbl[k].e_last});
      chk($sformatf("vec%0d_done", k), ndone, {31'd0, tbl[k].e_done});
      chk($sformatf("vec%0d_err", k), nerr, {31'd0, tbl[k].e_err});
      chk($sformatf("vec%0d_errcnt", k), {16'd0, ecnt}, exp_ecnt);
    end

    for (int i = 0; i < 2048; i++) bodyarr[i] = 8'($urandom);

    // payload FIFO full on body byte 3
    build(8'h00, 8, 8, 1, 2, 8'h40);
    fq[body_start + 2].pf = 1'b1;
    run_frame();
    exp_ecnt++;
    chk("pfull_nout", qp.size(), 2);
    chk("pfull_err", nerr, 1);
    chk("pfull_done", ndone, 0);

    // compressed FIFO full on a high byte is harmless, on a low byte it drops
    build(8'h01, 4, 4, 1, 2, 8'h40);
    fq[body_start + 2].cf = 1'b1;
    run_frame();
    chk("cfull_hi_nout", qc.size(), 2);
    chk("cfull_hi_done", ndone, 1);
    build(8'h01, 6, 6, 1, 2, 8'h40);
    fq[body_start + 3].cf = 1'b1;
    run_frame();
    exp_ecnt++;
    chk("cfull_lo_nout", qc.size(), 1);
    chk("cfull_lo_err", nerr, 1);

    // header FIFO full on header byte 6
    build(8'h00, 2, 2, 1, 2, 8'h40);
    fq[1 + 1 + 5].hf = 1'b1;
    run_frame();
    exp_ecnt++;
    chk("hfull_nhead", qh.size(), 5);
    chk("hfull_nout", qp.size(), 0);
    chk("hfull_err", nerr, 1);
    chk("hfull_errcnt", {16'd0, ecnt}, exp_ecnt);

    // reset in the middle of the body; later bytes mimic a preamble and must be ignored
    bodyarr[5] = 8'h55;
    bodyarr[6] = 8'hD5;
    build(8'h00, 8, 8, 1, 2, 8'h40);
    fq[body_start + 4].rs = 1'b1;
    run_frame();
    exp_ecnt = 0;
    chk("rstmid_nout", qp.size(), 4);
    chk("rstmid_pulses", ndone + nerr, 0);
    chk("rstmid_errcnt", {16'd0, ecnt}, 0);
    build(8'h02, 3, 3, 1, 2, 8'h40);
    run_frame();
    chk("rstmid_next_done", ndone, 1);
    chk("rstmid_next_nout", qd.size(), 3);

    for (int f = 0; f < 40; f++) begin
      r = $urandom_range(0, 9);
      ft = (r < 3) ? 8'h00 : (r < 5) ? 8'h01 : (r < 7) ? 8'h02 : (r < 8) ? 8'h03
                   : 8'($urandom_range(4, 255));
      len = $urandom_range(0, 40);
      if (ft == 8'h01 && $urandom_range(0, 9) < 7) len = len & ~1;
      if (ft == 8'h03 && $urandom_range(0, 3) != 0) len = 0;
      if ($urandom_range(0, 9) == 0) len = $urandom_range(ML + 1, 65535);
      for (int i = 0; i < 64; i++) bodyarr[i] = 8'($urandom);
      nsend = (len > ML) ? 3 : len;
      errpos = -1;
      r = $urandom_range(0, 3);
      if (len <= ML && r == 1) errpos = $urandom_range(0, len + 1);
      if (len <= ML && r == 2 && len > 0) nsend = $urandom_range(0, len - 1);
      ntail = (nsend < len) ? 0 : 2;
      npre = $urandom_range(1, 4);
      hb = 8'($urandom);
      build(ft, len, nsend, npre, ntail, hb);
      if (errpos >= 0) fq[body_start + errpos].er = 1'b1;
      model(ft, len, nsend, errpos, hb);
      if (e_err) exp_ecnt++;
      run_frame();
      check_model($sformatf("rnd%0d", f));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
